axi_led_pwm_nch: RTL

- Parametrised next-generation LED controller: one AXI4-Lite slave register file driving CHANNELS independent LED outputs.
- Each channel has PWM brightness and three modes: static, blink and breathe (triangular duty ramp).
- Replaces the fixed three-colour on/blink controller; sits between the PS AXI-Lite interconnect and the board LED pins.

---
 rtl/axi_led_pwm_nch.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_led_pwm_nch.sv
// AXI4-Lite controlled multi-channel LED driver: shared PWM counter plus a
// per-channel engine for static, blink and breathe (triangular duty) modes.
module axi_led_pwm_nch #(
  parameter int CHANNELS     = 3,
  parameter int PWM_WIDTH    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter bit INVERSE_MODE = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [2:0]            arprot,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [31:0]           rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [CHANNELS-1:0]   led
);
  localparam int IW = ADDR_WIDTH - 4;
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = {{(PWM_WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]                 r_ctrl;
  logic [15:0]                r_prescale, r_pre_cnt;
  logic [PWM_WIDTH-1:0]       r_pwm_cnt;
  logic                       r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                 r_bresp, r_rresp;
  logic [31:0]                r_rdata;
  logic [CHANNELS-1:0]        r_led;
  logic [CHANNELS-1:0]        w_state;
  logic [CHANNELS-1:0][31:0]  w_ch_rdata;
  logic                       w_tick, w_wr_fire, w_rd_fire, w_wr_err, w_rd_err;
  logic [IW-1:0]              w_wr_idx, w_rd_idx;
  logic [31:0]                w_rd_data;
  logic                       w_unused;

  assign w_unused  = ^{awprot, arprot, wstrb, awaddr[1:0], araddr[1:0]};
  assign awready   = r_awready;
  assign wready    = r_awready;
  assign bvalid    = r_bvalid;
  assign bresp     = r_bresp;
  assign arready   = r_arready;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign rresp     = r_rresp;
  assign led       = r_led;

  assign w_wr_fire = r_awready && awvalid && wvalid;
  assign w_rd_fire = r_arready && arvalid;
  assign w_wr_idx  = awaddr[ADDR_WIDTH-1:4];
  assign w_rd_idx  = araddr[ADDR_WIDTH-1:4];
  assign w_wr_err  = w_wr_idx > IW'(CHANNELS);
  assign w_rd_err  = w_rd_idx > IW'(CHANNELS);
  assign w_tick    = r_pre_cnt >= r_prescale;

  always_comb begin
    w_rd_data = '0;
    if (w_rd_idx == '0) begin
      case (araddr[3:2])
        2'd0:    w_rd_data = {30'd0, r_ctrl};
        2'd1:    w_rd_data = {16'd0, r_prescale};
        2'd2:    w_rd_data = {{(32-CHANNELS){1'b0}}, w_state};
        default: w_rd_data = '0;
      endcase
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (w_rd_idx == IW'(ch + 1)) w_rd_data = w_ch_rdata[ch];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= '0;
      r_rdata    <= '0;
      r_led      <= {CHANNELS{INVERSE_MODE}};
    end else begin
      // Ready is a single-cycle pulse; the !r_awready term stops a double accept
      r_awready <= awvalid && wvalid && !r_bvalid && !r_awready;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_err ? 2'b10 : 2'b00;
        if (w_wr_idx == '0) begin
          case (awaddr[3:2])
            2'd0:    r_ctrl     <= wdata[1:0];
            2'd1:    r_prescale <= wdata[15:0];
            default: ;
          endcase
        end
      end else if (bready) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= arvalid && !r_rvalid && !r_arready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
      end else if (rready) begin
        r_rvalid <= 1'b0;
      end
      r_pre_cnt <= w_tick ? 16'd0 : r_pre_cnt + 16'd1;
      if (w_tick) r_pwm_cnt <= (r_pwm_cnt >= PWM_MAX) ? '0 : r_pwm_cnt + 1'b1;
      r_led <= w_state ^ {CHANNELS{INVERSE_MODE}};
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                 r_en, r_phase, r_dir_dn, r_armed;
    logic [1:0]           r_mode, r_mode_q;
    logic [PWM_WIDTH-1:0] r_duty, r_eff;
    logic [31:0]          r_period, r_timer;
    logic                 w_we, w_clear, w_step, w_blink, w_breathe, w_on;
    logic [31:0]          w_per_m1;
    logic [PWM_WIDTH-1:0] w_eff;

    assign w_we      = w_wr_fire && (w_wr_idx == IW'(gi + 1));
    assign w_blink   = r_mode == 2'd1;
    assign w_breathe = r_mode == 2'd2;
    assign w_per_m1  = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;
    assign w_step    = r_timer >= w_per_m1;
    assign w_clear   = !r_en || r_ctrl[0] || (r_armed && r_mode != r_mode_q);
    assign w_eff     = w_breathe ? r_eff : r_duty;
    assign w_on      = (r_pwm_cnt < w_eff) && (!w_blink || r_phase);
    assign w_state[gi] = r_ctrl[1] && r_en && !r_ctrl[0] && w_on;
    assign w_ch_rdata[gi] =
        (araddr[3:2] == 2'd0) ? {{(24-PWM_WIDTH){1'b0}}, r_duty, 5'd0, r_mode, r_en} :
        (araddr[3:2] == 2'd1) ? r_period :
        (araddr[3:2] == 2'd2) ? {{(32-PWM_WIDTH){1'b0}}, w_eff} : 32'd0;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_en     <= 1'b0;
        r_mode   <= '0;
        r_duty   <= '0;
        r_period <= '0;
      end else if (w_we) begin
        case (awaddr[3:2])
          2'd0: begin
            r_en   <= wdata[0];
            r_mode <= wdata[2:1];
            r_duty <= wdata[8 +: PWM_WIDTH];
          end
          2'd1:    r_period <= wdata;
          default: ;
        endcase
      end
    end

    // Engine: cleared while disabled, armed one clock after release (phase=1)
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        r_mode_q <= '0;
        r_timer  <= '0;
        r_phase  <= 1'b0;
        r_eff    <= '0;
        r_dir_dn <= 1'b0;
        r_armed  <= 1'b0;
      end else begin
        r_mode_q <= r_mode;
        if (w_clear) begin
          r_timer  <= '0;
          r_phase  <= 1'b0;
          r_eff    <= '0;
          r_dir_dn <= 1'b0;
          r_armed  <= 1'b0;
        end else if (!r_armed) begin
          r_timer  <= '0;
          r_phase  <= 1'b1;
          r_eff    <= '0;
          r_dir_dn <= 1'b0;
          r_armed  <= 1'b1;
        end else begin
          r_timer <= w_step ? 32'd0 : r_timer + 32'd1;
          if (w_blink && w_step) r_phase <= ~r_phase;
          if (w_breathe) begin
            if (r_eff > r_duty) begin
              r_eff    <= r_duty;
              r_dir_dn <= 1'b1;
            end else if (r_duty == '0) begin
              r_eff    <= '0;
              r_dir_dn <= 1'b0;
            end else if (w_step) begin
              if (r_dir_dn ? (r_eff == '0) : (r_eff != r_duty)) begin
                r_eff    <= r_eff + 1'b1;
                r_dir_dn <= (r_eff + 1'b1) == r_duty;
              end else begin
                r_eff    <= r_eff - 1'b1;
                r_dir_dn <= r_eff != PWM_WIDTH'(1);
              end
            end
          end
        end
      end
    end
  end
endmodule
